// File: rtl/ps2_kbd_cmd_sequencer_pkg.sv
// Shared opcodes, keyboard response codes and FSM state type for the PS/2
// keyboard command sequencer.
package ps2_kbd_pkg;

   localparam logic [7:0] CMD_RESET     = 8'hFF;
   localparam logic [7:0] CMD_SET_LED   = 8'hED;
   localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;

   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_RESEND   = 8'hFE;
   localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
   localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

   localparam int TIMER_W = 26;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEND_CMD,
      ST_WAIT_TXD,
      ST_WAIT_ACK,
      ST_SEND_ARG,
      ST_WAIT_TXD_ARG,
      ST_WAIT_ARG_ACK,
      ST_WAIT_BAT,
      ST_DONE,
      ST_ERR
   } state_e;

endpackage

// File: rtl/ps2_kbd_cmd_sequencer_if.sv
// Byte-level link between the sequencer, the PS/2 transceiver and the
// scancode decoder; master is the sequencer side.
interface ps2_kbd_cmd_sequencer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] scan_data;
   logic       scan_valid;

   modport master (
      output tx_data, tx_valid, scan_data, scan_valid,
      input  tx_ready, tx_done, rx_data, rx_valid
   );

   modport slave (
      input  tx_data, tx_valid, scan_data, scan_valid,
      output tx_ready, tx_done, rx_data, rx_valid
   );
endinterface

// File: rtl/ps2_kbd_cmd_sequencer_timer.sv
// Response timer: counts up from zero after each clear and flags the last
// cycle of the window set by limit_i.
module ps2_cmd_timer
   import ps2_kbd_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic [W-1:0] limit_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = clr_i ? '0 : cnt_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == limit_i - W'(1));

endmodule

// File: rtl/ps2_kbd_cmd_sequencer.sv
// Host-side PS/2 keyboard command sequencer: arbitrates reset/LED/typematic
// requests, sends opcode and argument with ACK/resend/timeout handling.
// Optional build macro KBD_INIT_ON_RESET_EN issues a keyboard reset after
// every system reset.
//
// state            | meaning
// ST_IDLE          | arbitrate requests, forward rx bytes as scancodes
// ST_SEND_CMD      | offer opcode byte to transceiver
// ST_WAIT_TXD      | opcode accepted, wait for tx_done
// ST_WAIT_ACK      | wait for 0xFA to the opcode
// ST_SEND_ARG      | offer argument byte
// ST_WAIT_TXD_ARG  | argument accepted, wait for tx_done
// ST_WAIT_ARG_ACK  | wait for 0xFA to the argument
// ST_WAIT_BAT      | reset acknowledged, wait for self-test result
// ST_DONE          | pulse cmd_done
// ST_ERR           | command failed, cmd_error already set
module ps2_kbd_cmd_sequencer
   import ps2_kbd_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 1_000_000,
   parameter int unsigned BAT_TIMEOUT = 37_500_000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       init_req,
   input  logic       led_req,
   input  logic [2:0] led_val,
   input  logic       rate_req,
   input  logic [7:0] rate_val,
   ps2_kbd_cmd_sequencer_if.master kbd,
   output logic       busy,
   output logic       cmd_done,
   output logic       cmd_error
);

   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam logic [RW-1:0]      MAX_RETRY_W = RW'(MAX_RETRY);
   localparam logic [TIMER_W-1:0] ACK_LIM     = TIMER_W'(ACK_TIMEOUT);
   localparam logic [TIMER_W-1:0] BAT_LIM     = TIMER_W'(BAT_TIMEOUT);

   state_e        state_q, state_d;
   logic [7:0]    opcode_q, opcode_d;
   logic [7:0]    arg_q, arg_d;
   logic          has_arg_q, has_arg_d;
   logic          is_init_q, is_init_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [RW-1:0] retry_inc;
   logic          retry_ok;
   logic          cmd_error_q, cmd_error_d;

   logic          grant;
   logic          init_any;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic          timer_clr;
   logic          timer_exp;
   logic [TIMER_W-1:0] timer_limit;

   logic rx_ack, rx_resend, rx_bat_ok, rx_bat_fail;

`ifdef KBD_INIT_ON_RESET_EN
   // Pending synthetic reset request, armed by system reset.
   logic auto_init_q;

   always_ff @(posedge CLOCK_50) begin
      if (reset)      auto_init_q <= 1'b1;
      else if (grant) auto_init_q <= 1'b0;
   end

   assign init_any = init_req | auto_init_q;
`else
   assign init_any = init_req;
`endif

   assign rx_ack      = kbd.rx_valid && (kbd.rx_data == RSP_ACK);
   assign rx_resend   = kbd.rx_valid && (kbd.rx_data == RSP_RESEND);
   assign rx_bat_ok   = kbd.rx_valid && (kbd.rx_data == RSP_BAT_OK);
   assign rx_bat_fail = kbd.rx_valid && (kbd.rx_data == RSP_BAT_FAIL);

   assign retry_inc = retry_q + RW'(1);
   assign retry_ok  = (retry_inc <= MAX_RETRY_W);

   always_comb begin
      state_d     = state_q;
      opcode_d    = opcode_q;
      arg_d       = arg_q;
      has_arg_d   = has_arg_q;
      is_init_d   = is_init_q;
      retry_d     = retry_q;
      cmd_error_d = cmd_error_q;
      grant       = 1'b0;
      tx_valid    = 1'b0;
      tx_data     = '0;

      case (state_q)
         ST_IDLE: begin
            if (init_any) begin
               grant     = 1'b1;
               opcode_d  = CMD_RESET;
               arg_d     = '0;
               has_arg_d = 1'b0;
               is_init_d = 1'b1;
            end else if (led_req) begin
               grant     = 1'b1;
               opcode_d  = CMD_SET_LED;
               arg_d     = {5'b0, led_val};
               has_arg_d = 1'b1;
               is_init_d = 1'b0;
            end else if (rate_req) begin
               grant     = 1'b1;
               opcode_d  = CMD_TYPEMATIC;
               arg_d     = rate_val & 8'h7F;
               has_arg_d = 1'b1;
               is_init_d = 1'b0;
            end
            if (grant) begin
               retry_d     = '0;
               cmd_error_d = 1'b0;
               state_d     = ST_SEND_CMD;
            end
         end

         ST_SEND_CMD: begin
            tx_valid = 1'b1;
            tx_data  = opcode_q;
            if (kbd.tx_ready) state_d = ST_WAIT_TXD;
         end

         ST_WAIT_TXD: begin
            if (kbd.tx_done) state_d = ST_WAIT_ACK;
         end

         ST_WAIT_ACK: begin
            if (rx_ack) begin
               if (has_arg_q)      state_d = ST_SEND_ARG;
               else if (is_init_q) state_d = ST_WAIT_BAT;
               else                state_d = ST_DONE;
            end else if (rx_resend || timer_exp) begin
               retry_d = retry_inc;
               if (retry_ok) begin
                  state_d = ST_SEND_CMD;
               end else begin
                  state_d     = ST_ERR;
                  cmd_error_d = 1'b1;
               end
            end
         end

         ST_SEND_ARG: begin
            tx_valid = 1'b1;
            tx_data  = arg_q;
            if (kbd.tx_ready) state_d = ST_WAIT_TXD_ARG;
         end

         ST_WAIT_TXD_ARG: begin
            if (kbd.tx_done) state_d = ST_WAIT_ARG_ACK;
         end

         ST_WAIT_ARG_ACK: begin
            // Opcode and argument draw on the same retry budget.
            if (rx_ack) begin
               state_d = ST_DONE;
            end else if (rx_resend || timer_exp) begin
               retry_d = retry_inc;
               if (retry_ok) begin
                  state_d = ST_SEND_ARG;
               end else begin
                  state_d     = ST_ERR;
                  cmd_error_d = 1'b1;
               end
            end
         end

         ST_WAIT_BAT: begin
            if (rx_bat_ok) begin
               state_d = ST_DONE;
            end else if (rx_bat_fail || timer_exp) begin
               state_d     = ST_ERR;
               cmd_error_d = 1'b1;
            end
         end

         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         opcode_q    <= '0;
         arg_q       <= '0;
         has_arg_q   <= 1'b0;
         is_init_q   <= 1'b0;
         retry_q     <= '0;
         cmd_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         opcode_q    <= opcode_d;
         arg_q       <= arg_d;
         has_arg_q   <= has_arg_d;
         is_init_q   <= is_init_d;
         retry_q     <= retry_d;
         cmd_error_q <= cmd_error_d;
      end
   end

   assign timer_clr   = (state_d != state_q);
   assign timer_limit = (state_q == ST_WAIT_BAT) ? BAT_LIM : ACK_LIM;

   ps2_cmd_timer #(.W(TIMER_W)) u_timer (
      .clk       (CLOCK_50),
      .reset     (reset),
      .clr_i     (timer_clr),
      .limit_i   (timer_limit),
      .expired_o (timer_exp)
   );

   assign kbd.tx_valid   = tx_valid;
   assign kbd.tx_data    = tx_data;
   assign kbd.scan_valid = kbd.rx_valid && (state_q == ST_IDLE) && !grant;
   assign kbd.scan_data  = kbd.scan_valid ? kbd.rx_data : 8'h00;

   assign busy      = (state_q != ST_IDLE);
   assign cmd_done  = (state_q == ST_DONE);
   assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_ps2_kbd_cmd_sequencer.sv
// Directed bench for ps2_kbd_cmd_sequencer: table of single commands plus
// hand-written retry, timeout, BAT, priority, passthrough and reset sequences.
module tb_ps2_kbd_cmd_sequencer;
   import ps2_kbd_pkg::*;

   localparam int ACK_T = 100;
   localparam int BAT_T = 2000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       init_req = 1'b0, led_req = 1'b0, rate_req = 1'b0;
   logic [2:0] led_val = 3'b000;
   logic [7:0] rate_val = 8'h00;
   logic       busy, cmd_done, cmd_error;

   ps2_kbd_cmd_sequencer_if kbd();

   ps2_kbd_cmd_sequencer #(
      .ACK_TIMEOUT (ACK_T),
      .BAT_TIMEOUT (BAT_T),
      .MAX_RETRY   (3)
   ) dut (
      .CLOCK_50  (clk),
      .reset     (reset),
      .init_req  (init_req),
      .led_req   (led_req),
      .led_val   (led_val),
      .rate_req  (rate_req),
      .rate_val  (rate_val),
      .kbd       (kbd),
      .busy      (busy),
      .cmd_done  (cmd_done),
      .cmd_error (cmd_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       init;
      logic       led;
      logic       rate;
      logic [2:0] lv;
      logic [7:0] rv;
      logic [7:0] op;
      logic [7:0] arg;
      bit         has_arg;
      bit         is_init;
      int         hold;
   } vec_t;

   vec_t vecs[5];
   logic [7:0] pt_bytes[4];

   int checks = 0, failures = 0;
   int n_tx = 0, n_done = 0, bad_scan = 0, cyc = 0;
   int hs_cyc[$];
   logic [7:0] tx_log[$];
   int tx0, d0, s0, t0, h0, c0, c1;
   bit got_done, got_err;

   // Observer sampled 2 time units after the falling edge.
   always begin
      @(negedge clk);
      #2;
      cyc++;
      if (kbd.tx_valid === 1'b1 && kbd.tx_ready === 1'b1) begin
         n_tx++;
         tx_log.push_back(kbd.tx_data);
         hs_cyc.push_back(cyc);
      end
      if (cmd_done === 1'b1) n_done++;
      if (kbd.scan_valid === 1'b1 && busy === 1'b1) bad_scan++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input string name, input logic [7:0] req, input int hold);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (kbd.tx_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({name, " offered"}, 32'(seen), 32'd1);
      if (seen) begin
         check({name, " data"}, 32'(kbd.tx_data), 32'(req));
         if (hold > 0) begin
            tick(hold);
            check({name, " held"}, 32'({kbd.tx_valid, kbd.tx_data}), 32'({1'b1, req}));
         end
         kbd.tx_ready = 1'b1;
         @(negedge clk);
         kbd.tx_ready = 1'b0;
         tick(2);
         kbd.tx_done = 1'b1;
         @(negedge clk);
         kbd.tx_done = 1'b0;
      end
   endtask

   task automatic rx_byte(input logic [7:0] b);
      kbd.rx_data  = b;
      kbd.rx_valid = 1'b1;
      @(negedge clk);
      kbd.rx_valid = 1'b0;
      kbd.rx_data  = 8'h00;
   endtask

   task automatic wait_end(input int budget, output bit done, output bit err);
      done = 1'b0;
      err  = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (cmd_done === 1'b1) begin
            done = 1'b1;
            break;
         end
         if (cmd_error === 1'b1) begin
            err = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic service_auto_init();
`ifdef KBD_INIT_ON_RESET_EN
      bit d, e;
      send_byte("auto init op", CMD_RESET, 0);
      rx_byte(RSP_ACK);
      rx_byte(RSP_BAT_OK);
      wait_end(50, d, e);
      check("auto init done", 32'(d), 32'd1);
      tick(2);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      kbd.tx_ready = 1'b0;
      kbd.tx_done  = 1'b0;
      kbd.rx_data  = 8'h00;
      kbd.rx_valid = 1'b0;

      vecs[0] = '{1'b0, 1'b1, 1'b0, 3'b101, 8'h00, 8'hED, 8'h05, 1'b1, 1'b0, 0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 3'b010, 8'hFF, 8'hED, 8'h02, 1'b1, 1'b0, 2};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 3'b000, 8'hAB, 8'hF3, 8'h2B, 1'b1, 1'b0, 1};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 3'b111, 8'h7F, 8'hED, 8'h07, 1'b1, 1'b0, 0};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 3'b011, 8'h10, 8'hFF, 8'h00, 1'b0, 1'b1, 3};
      pt_bytes = '{8'h1C, 8'hFA, 8'hAA, 8'h00};

      // Reset values
      tick(3);
      check("rst tx_valid", 32'(kbd.tx_valid), 32'd0);
      check("rst tx_data", 32'(kbd.tx_data), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst cmd_done", 32'(cmd_done), 32'd0);
      check("rst cmd_error", 32'(cmd_error), 32'd0);
      check("rst scan_valid", 32'(kbd.scan_valid), 32'd0);
      reset = 1'b0;
      service_auto_init();
      tick(2);

      // Passthrough in IDLE, same-cycle strobe
      for (int p = 0; p < 4; p++) begin
         kbd.rx_data  = pt_bytes[p];
         kbd.rx_valid = 1'b1;
         #1;
         check("pt scan_valid", 32'(kbd.scan_valid), 32'd1);
         check("pt scan_data", 32'(kbd.scan_data), 32'(pt_bytes[p]));
         @(negedge clk);
         kbd.rx_valid = 1'b0;
         #1;
         check("pt scan_valid low", 32'(kbd.scan_valid), 32'd0);
      end

      // Table of single commands, each ACKed, with a stray byte in WAIT_ACK
      for (int v = 0; v < 5; v++) begin
         tx0 = n_tx;
         d0  = n_done;
         s0  = bad_scan;
         init_req = vecs[v].init;
         led_req  = vecs[v].led;
         rate_req = vecs[v].rate;
         led_val  = vecs[v].lv;
         rate_val = vecs[v].rv;
         tick(1);
         check("vec busy after grant", 32'(busy), 32'd1);
         send_byte("vec opcode", vecs[v].op, vecs[v].hold);
         rx_byte(8'h55);
         rx_byte(RSP_ACK);
         if (vecs[v].has_arg) begin
            send_byte("vec arg", vecs[v].arg, 0);
            rx_byte(RSP_ACK);
         end
         if (vecs[v].is_init) begin
            tick(20);
            rx_byte(RSP_BAT_OK);
         end
         wait_end(50, got_done, got_err);
         check("vec done", 32'(got_done), 32'd1);
         check("vec error", 32'(got_err), 32'd0);
         init_req = 1'b0;
         led_req  = 1'b0;
         rate_req = 1'b0;
         tick(1);
         check("vec busy after done", 32'(busy), 32'd0);
         check("vec done pulse width", 32'(cmd_done), 32'd0);
         check("vec tx count", 32'(n_tx - tx0), vecs[v].has_arg ? 32'd2 : 32'd1);
         check("vec done count", 32'(n_done - d0), 32'd1);
         check("vec no scan while busy", 32'(bad_scan - s0), 32'd0);
         tick(2);
      end

      // Init with BAT 1000 cycles after ACK
      init_req = 1'b1;
      send_byte("init op", CMD_RESET, 0);
      rx_byte(RSP_ACK);
      tick(1000);
      check("init busy in bat wait", 32'(busy), 32'd1);
      rx_byte(RSP_BAT_OK);
      wait_end(20, got_done, got_err);
      check("init bat done", 32'(got_done), 32'd1);
      init_req = 1'b0;
      tick(3);

      // Init with BAT failure: error, no retry
      init_req = 1'b1;
      tx0 = n_tx;
      send_byte("init fail op", CMD_RESET, 0);
      rx_byte(RSP_ACK);
      tick(10);
      rx_byte(RSP_BAT_FAIL);
      wait_end(20, got_done, got_err);
      check("bat fail error", 32'(got_err), 32'd1);
      check("bat fail no done", 32'(got_done), 32'd0);
      init_req = 1'b0;
      tick(300);
      check("bat fail no retry tx", 32'(n_tx - tx0), 32'd1);
      check("bat fail sticky", 32'(cmd_error), 32'd1);
      check("bat fail idle", 32'(busy), 32'd0);

      // Init with BAT timeout; grant also clears the sticky error
      init_req = 1'b1;
      tick(1);
      check("grant clears error", 32'(cmd_error), 32'd0);
      send_byte("bat to op", CMD_RESET, 0);
      rx_byte(RSP_ACK);
      c0 = cyc;
      wait_end(BAT_T + 50, got_done, got_err);
      c1 = cyc;
      check("bat timeout error", 32'(got_err), 32'd1);
      check("bat timeout span", 32'(c1 - c0), 32'(BAT_T));
      init_req = 1'b0;
      tick(3);

      // Typematic with three resends of the opcode
      rate_req = 1'b1;
      rate_val = 8'hC5;
      tx0 = n_tx;
      t0  = tx_log.size();
      repeat (3) begin
         send_byte("rate retry op", CMD_TYPEMATIC, 0);
         rx_byte(RSP_RESEND);
      end
      send_byte("rate final op", CMD_TYPEMATIC, 0);
      rx_byte(RSP_ACK);
      send_byte("rate arg", 8'h45, 0);
      rx_byte(RSP_ACK);
      wait_end(20, got_done, got_err);
      check("rate retry done", 32'(got_done), 32'd1);
      rate_req = 1'b0;
      tick(2);
      check("rate retry tx count", 32'(n_tx - tx0), 32'd5);
      if (tx_log.size() >= t0 + 5) begin
         check("rate 4th op", 32'(tx_log[t0 + 3]), 32'(CMD_TYPEMATIC));
         check("rate arg once", 32'(tx_log[t0 + 4]), 32'h45);
      end

      // LED with no response: 4 sends, ACK_T-driven spacing, then error
      led_req = 1'b1;
      led_val = 3'b100;
      tx0 = n_tx;
      h0  = hs_cyc.size();
      repeat (4) send_byte("led timeout op", CMD_SET_LED, 0);
      wait_end(300, got_done, got_err);
      check("led timeout error", 32'(got_err), 32'd1);
      led_req = 1'b0;
      for (int k = 1; k < 4; k++) begin
         if (hs_cyc.size() > h0 + k)
            check("led resend spacing", 32'(hs_cyc[h0 + k] - hs_cyc[h0 + k - 1]), 32'(ACK_T + 4));
      end
      tick(300);
      check("led timeout sends", 32'(n_tx - tx0), 32'd4);

      // Priority: init > led > rate
      init_req = 1'b1;
      led_req  = 1'b1;
      rate_req = 1'b1;
      led_val  = 3'b110;
      rate_val = 8'h2A;
      send_byte("prio first", CMD_RESET, 0);
      rx_byte(RSP_ACK);
      tick(5);
      rx_byte(RSP_BAT_OK);
      wait_end(20, got_done, got_err);
      check("prio init done", 32'(got_done), 32'd1);
      init_req = 1'b0;
      send_byte("prio second", CMD_SET_LED, 0);
      rx_byte(RSP_ACK);
      send_byte("prio led arg", 8'h06, 0);
      rx_byte(RSP_ACK);
      wait_end(20, got_done, got_err);
      check("prio led done", 32'(got_done), 32'd1);
      led_req = 1'b0;
      send_byte("prio third", CMD_TYPEMATIC, 0);
      rx_byte(RSP_ACK);
      send_byte("prio rate arg", 8'h2A, 0);
      rx_byte(RSP_ACK);
      wait_end(20, got_done, got_err);
      check("prio rate done", 32'(got_done), 32'd1);
      rate_req = 1'b0;
      tick(3);

      // rx strobe coinciding with a grant is dropped
      led_req  = 1'b1;
      led_val  = 3'b001;
      kbd.rx_data  = 8'h1C;
      kbd.rx_valid = 1'b1;
      #1;
      check("grant drops rx", 32'(kbd.scan_valid), 32'd0);
      @(negedge clk);
      kbd.rx_valid = 1'b0;
      send_byte("grant rx op", CMD_SET_LED, 0);
      rx_byte(RSP_ACK);
      send_byte("grant rx arg", 8'h01, 0);
      rx_byte(RSP_ACK);
      wait_end(20, got_done, got_err);
      check("grant rx done", 32'(got_done), 32'd1);
      led_req = 1'b0;
      tick(3);

      // Reset while the opcode is offered
      led_req = 1'b1;
      tick(2);
      check("offer before reset", 32'(kbd.tx_valid), 32'd1);
      reset   = 1'b1;
      led_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("reset drops tx_valid", 32'(kbd.tx_valid), 32'd0);
      check("reset drops busy (send)", 32'(busy), 32'd0);
      service_auto_init();
      tick(2);

      // Reset during WAIT_ACK
      led_req = 1'b1;
      send_byte("reset ack op", CMD_SET_LED, 0);
      tick(5);
      d0 = n_done;
      reset   = 1'b1;
      led_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("reset ack tx_valid", 32'(kbd.tx_valid), 32'd0);
      check("reset ack busy", 32'(busy), 32'd0);
      check("reset ack no error", 32'(cmd_error), 32'd0);
      check("reset ack no done", 32'(cmd_done), 32'd0);
      service_auto_init();
      d0 = n_done;
      tick(200);
      check("reset ack quiet done", 32'(n_done - d0), 32'd0);
      check("reset ack quiet error", 32'(cmd_error), 32'd0);
      check("no scan while busy total", 32'(bad_scan), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
